bus_initiator_subsystem: RTL and testbench

Initiator-side slice of the serial bus: one initiator port, the bus arbiter and the address decoder, integrated as one block. The initiator core hands over a 16-bit address (plus 8-bit write data) and the port serializes it onto a 1-bit bus once the arbiter grants it. For reads, the port deserializes the 8-bit response from the target. The decoder snoops the serial address and selects one of three targets.

---
 rtl/bus_initiator_subsystem.sv | 209 ++++++++++++++++++++
 tb/tb_bus_initiator_subsystem.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_initiator_subsystem.sv
// Initiator-side slice of the serial bus: one initiator port that serializes
// address/write data and collects read data, the three-way bus arbiter, and
// the address decoder that snoops the serial address stream.
module bus_initiator_subsystem (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init_req,
    input  logic [15:0] init_addr_out,
    input  logic        init_addr_out_valid,
    input  logic [7:0]  init_data_out,
    input  logic        init_data_out_valid,
    input  logic        init_rw,
    input  logic        init_ready,
    input  logic        target_split,
    input  logic        target_ack,
    input  logic        bus_data_in,
    input  logic        bus_data_in_valid,
    input  logic        req_i_2,
    input  logic        req_split,
    input  logic        split,
    output logic        bus_data_out,
    output logic        bus_data_out_valid,
    output logic        bus_mode,
    output logic        init_grant,
    output logic [7:0]  init_data_in,
    output logic        init_data_in_valid,
    output logic        init_ack,
    output logic        bus_init_rw,
    output logic        bus_init_ready,
    output logic        init_split_ack,
    output logic        grant_i_2,
    output logic        grant_split,
    output logic        target_1_valid,
    output logic        target_2_valid,
    output logic        target_3_valid,
    output logic [1:0]  sel
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_ADDR, S_WDATA, S_RWAIT, S_SPLIT, S_DONE
    } state_t;

    state_t      state;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic [6:0]  rdata_q;     // first seven read bits; the eighth goes straight out
    logic [3:0]  cnt;
    logic        acked;
    logic        arbiter_req;
    logic        grant_i_1;
    logic        arb_hold;
    logic        arb_busy;
    logic [2:0]  dec_tail;    // last three address bits seen, enough to form addr[15:12]
    logic [3:0]  dec_cnt;
    logic        unused;

    // A split resume carries no information once the port is already collecting.
    assign unused = target_ack;

    // Port FSM: latch request, wait for grant, stream address/data, collect read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= S_IDLE;
            addr_q             <= '0;
            wdata_q            <= '0;
            rdata_q            <= '0;
            cnt                <= '0;
            acked              <= 1'b0;
            arbiter_req        <= 1'b0;
            bus_data_out       <= 1'b0;
            bus_data_out_valid <= 1'b0;
            bus_mode           <= 1'b0;
            init_grant         <= 1'b0;
            init_data_in       <= '0;
            init_data_in_valid <= 1'b0;
            init_ack           <= 1'b0;
            bus_init_rw        <= 1'b0;
            bus_init_ready     <= 1'b0;
            init_split_ack     <= 1'b0;
        end else begin
            init_ack           <= 1'b0;
            init_data_in_valid <= 1'b0;
            init_split_ack     <= 1'b0;
            bus_init_ready     <= init_ready;
            init_grant         <= grant_i_1;
            case (state)
                S_IDLE: begin
                    acked <= 1'b0;
                    if (init_addr_out_valid) addr_q  <= init_addr_out;
                    if (init_data_out_valid) wdata_q <= init_data_out;
                    if (init_req) begin
                        arbiter_req <= 1'b1;
                        state       <= S_REQ;
                    end
                end
                S_REQ: if (grant_i_1) begin
                    // Bit 0 goes out on the grant edge so the stream starts one cycle after grant.
                    bus_init_rw        <= init_rw;
                    bus_data_out       <= addr_q[0];
                    bus_data_out_valid <= 1'b1;
                    bus_mode           <= 1'b1;
                    cnt                <= 4'd1;
                    state              <= S_ADDR;
                end
                S_ADDR: begin
                    bus_data_out <= addr_q[cnt];
                    cnt          <= cnt + 4'd1;
                    if (cnt == 4'd15)
                        state <= bus_init_rw ? S_WDATA : S_RWAIT;
                end
                S_WDATA: begin
                    bus_data_out <= wdata_q[cnt[2:0]];
                    bus_mode     <= 1'b0;
                    if (cnt == 4'd7) begin
                        cnt   <= '0;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                S_RWAIT, S_SPLIT: begin
                    bus_data_out       <= 1'b0;
                    bus_data_out_valid <= 1'b0;
                    bus_mode           <= 1'b0;
                    if (bus_data_in_valid) begin
                        rdata_q <= {bus_data_in, rdata_q[6:1]};
                        if (cnt == 4'd7) begin
                            init_data_in       <= {bus_data_in, rdata_q};
                            init_data_in_valid <= 1'b1;
                            cnt                <= '0;
                            state              <= S_DONE;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                    // Completing the read wins over a split arriving on the same cycle.
                    if (state == S_RWAIT && target_split && !(bus_data_in_valid && cnt == 4'd7)) begin
                        init_split_ack <= 1'b1;
                        arbiter_req    <= 1'b0;
                        state          <= S_SPLIT;
                    end
                end
                S_DONE: begin
                    bus_data_out       <= 1'b0;
                    bus_data_out_valid <= 1'b0;
                    bus_mode           <= 1'b0;
                    if (!acked) begin
                        init_ack <= 1'b1;
                        acked    <= 1'b1;
                    end else if (!init_req) begin
                        arbiter_req <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign arb_hold = (grant_split && req_split) || (grant_i_1 && arbiter_req) || (grant_i_2 && req_i_2);
    assign arb_busy = grant_split || grant_i_1 || grant_i_2;

    // Arbiter: fixed priority, no preemption, one idle cycle between owners.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_split <= 1'b0;
            grant_i_1   <= 1'b0;
            grant_i_2   <= 1'b0;
        end else if (arb_busy && !arb_hold) begin
            grant_split <= 1'b0;
            grant_i_1   <= 1'b0;
            grant_i_2   <= 1'b0;
        end else if (!arb_busy) begin
            grant_split <= req_split;
            grant_i_1   <= !req_split && arbiter_req;
            grant_i_2   <= !req_split && !arbiter_req && req_i_2;
        end
    end

    // Decoder: snoop address bits, decode the top nibble on the 16th bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_tail       <= '0;
            dec_cnt        <= '0;
            sel            <= 2'b11;
            target_1_valid <= 1'b0;
            target_2_valid <= 1'b0;
            target_3_valid <= 1'b0;
        end else if (!split && bus_data_out_valid && bus_mode) begin
            dec_tail <= {bus_data_out, dec_tail[2:1]};
            dec_cnt  <= dec_cnt + 4'd1;
            if (dec_cnt == 4'd0) begin
                sel            <= 2'b11;
                target_1_valid <= 1'b0;
                target_2_valid <= 1'b0;
                target_3_valid <= 1'b0;
            end
            if (dec_cnt == 4'd15) begin
                case ({bus_data_out, dec_tail})
                    4'h0:    begin sel <= 2'b00; target_1_valid <= 1'b1; end
                    4'h4:    begin sel <= 2'b01; target_2_valid <= 1'b1; end
                    4'h8:    begin sel <= 2'b10; target_3_valid <= 1'b1; end
                    default: sel <= 2'b11;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bus_initiator_subsystem.sv
// Directed bench for bus_initiator_subsystem: writes, reads, split read,
// decode targets, arbitration order and reset in the middle of a transfer.
module tb_bus_initiator_subsystem;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        init_req = 0, init_addr_out_valid = 0, init_data_out_valid = 0;
    logic [15:0] init_addr_out = '0;
    logic [7:0]  init_data_out = '0;
    logic        init_rw = 0, init_ready = 0, target_split = 0, target_ack = 0;
    logic        bus_data_in = 0, bus_data_in_valid = 0, req_i_2 = 0, req_split = 0, split = 0;
    logic        bus_data_out, bus_data_out_valid, bus_mode, init_grant;
    logic [7:0]  init_data_in;
    logic        init_data_in_valid, init_ack, bus_init_rw, bus_init_ready, init_split_ack;
    logic        grant_i_2, grant_split, target_1_valid, target_2_valid, target_3_valid;
    logic [1:0]  sel;
    logic [14:0] ctl;

    int ncmp = 0, nerr = 0, dv_pulses = 0;
    logic t12_seen = 0, gi2_busy = 0;

    bus_initiator_subsystem dut (
        .clk(clk), .rst_n(rst_n), .init_req(init_req),
        .init_addr_out(init_addr_out), .init_addr_out_valid(init_addr_out_valid),
        .init_data_out(init_data_out), .init_data_out_valid(init_data_out_valid),
        .init_rw(init_rw), .init_ready(init_ready), .target_split(target_split),
        .target_ack(target_ack), .bus_data_in(bus_data_in), .bus_data_in_valid(bus_data_in_valid),
        .req_i_2(req_i_2), .req_split(req_split), .split(split),
        .bus_data_out(bus_data_out), .bus_data_out_valid(bus_data_out_valid), .bus_mode(bus_mode),
        .init_grant(init_grant), .init_data_in(init_data_in), .init_data_in_valid(init_data_in_valid),
        .init_ack(init_ack), .bus_init_rw(bus_init_rw), .bus_init_ready(bus_init_ready),
        .init_split_ack(init_split_ack), .grant_i_2(grant_i_2), .grant_split(grant_split),
        .target_1_valid(target_1_valid), .target_2_valid(target_2_valid),
        .target_3_valid(target_3_valid), .sel(sel)
    );

    always #5 clk = ~clk;

    assign ctl = {bus_data_out, bus_data_out_valid, bus_mode, init_grant, init_data_in_valid,
                  init_ack, bus_init_rw, bus_init_ready, init_split_ack, grant_i_2, grant_split,
                  target_1_valid, target_2_valid, target_3_valid, |init_data_in};

    // Event monitors sampled away from the active edge.
    always @(negedge clk) begin
        if (init_data_in_valid) dv_pulses++;
        if (target_1_valid || target_2_valid) t12_seen = 1'b1;
        if (grant_i_2 && bus_data_out_valid) gi2_busy = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start(input logic [15:0] a, input logic [7:0] d, input logic rw);
        init_addr_out = a; init_addr_out_valid = 1; init_data_out = d; init_data_out_valid = 1;
        init_rw = rw; init_req = 1;
        @(negedge clk);
        init_addr_out_valid = 0; init_data_out_valid = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus_data_out_valid) break;
            @(negedge clk);
        end
        chk("start_vld", bus_data_out_valid, 1);
    endtask

    task automatic addr_phase(input logic [15:0] a);
        logic [15:0] got, md;
        logic allv;
        allv = 1;
        for (int i = 0; i < 16; i++) begin
            got[i] = bus_data_out; md[i] = bus_mode; allv &= bus_data_out_valid;
            @(negedge clk);
        end
        chk("addr_bits", got, a);
        chk("addr_mode", md, 16'hFFFF);
        chk("addr_vld", allv, 1);
    endtask

    task automatic data_phase(input logic [7:0] d);
        logic [7:0] got, md;
        logic allv;
        allv = 1;
        for (int i = 0; i < 8; i++) begin
            got[i] = bus_data_out; md[i] = bus_mode; allv &= bus_data_out_valid;
            @(negedge clk);
        end
        chk("wdata_bits", got, d);
        chk("wdata_mode", md, 0);
        chk("wdata_vld", allv, 1);
    endtask

    task automatic rd_phase(input logic [7:0] rsp, input int split_at);
        for (int i = 0; i < 8; i++) begin
            if (i == split_at) begin
                bus_data_in_valid = 0;
                target_split = 1; @(negedge clk); target_split = 0;
                chk("split_ack", init_split_ack, 1);
                target_ack = 1; @(negedge clk); target_ack = 0;
                chk("split_ack_pulse", init_split_ack, 0);
                @(negedge clk);
                chk("split_grant_drop", init_grant, 0);
            end
            bus_data_in = rsp[i]; bus_data_in_valid = 1;
            @(negedge clk);
        end
        bus_data_in_valid = 0; bus_data_in = 0;
        chk("rd_vld", init_data_in_valid, 1);
        chk("rd_data", init_data_in, rsp);
        @(negedge clk);
        chk("rd_vld_pulse", init_data_in_valid, 0);
    endtask

    task automatic finish_xfer();
        chk("ack", init_ack, 1);
        chk("bus_idle", bus_data_out_valid, 0);
        init_req = 0;
        @(negedge clk);
        chk("ack_pulse", init_ack, 0);
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d);
        start(a, d, 1);
        addr_phase(a);
        data_phase(d);
        finish_xfer();
    endtask

    initial begin
        #2 rst_n = 0;
        @(negedge clk); @(negedge clk);
        chk("rst_ctl", ctl, 0);
        chk("rst_sel", sel, 2'b11);
        rst_n = 1; init_ready = 1;
        @(negedge clk);
        chk("ready_reg", bus_init_ready, 1);

        // Write 0x800A / 0x5C to T3
        t12_seen = 0;
        do_write(16'h800A, 8'h5C);
        chk("w_t3", {target_1_valid, target_2_valid, target_3_valid}, 3'b001);
        chk("w_sel", sel, 2'b10);
        chk("w_t12", t12_seen, 0);
        chk("w_rw", bus_init_rw, 1);

        // Read 0x8F44, target returns 0xA7
        dv_pulses = 0;
        start(16'h8F44, 8'h00, 0);
        addr_phase(16'h8F44);
        rd_phase(8'hA7, -1);
        finish_xfer();
        chk("r_pulses", dv_pulses, 1);
        chk("r_t3", {target_1_valid, target_2_valid, target_3_valid}, 3'b001);
        chk("r_sel", sel, 2'b10);
        chk("r_rw", bus_init_rw, 0);

        // Decode table
        do_write(16'h0123, 8'h01);
        chk("d_t1", {target_1_valid, target_2_valid, target_3_valid, sel}, 5'b100_00);
        do_write(16'h4FFF, 8'h02);
        chk("d_t2", {target_1_valid, target_2_valid, target_3_valid, sel}, 5'b010_01);
        do_write(16'hC000, 8'h03);
        chk("d_none", {target_1_valid, target_2_valid, target_3_valid, sel}, 5'b000_11);

        // Arbitration: split first, then port over req_i_2, then req_i_2
        req_split = 1; req_i_2 = 1;
        @(negedge clk); @(negedge clk);
        chk("arb_split", {grant_split, grant_i_2}, 2'b10);
        req_split = 0; gi2_busy = 0;
        start(16'h0123, 8'h11, 1);
        chk("arb_port", {init_grant, grant_i_2, grant_split}, 3'b100);
        addr_phase(16'h0123);
        data_phase(8'h11);
        finish_xfer();
        chk("arb_no_i2_busy", gi2_busy, 0);
        @(negedge clk);
        chk("arb_gap", grant_i_2, 0);
        @(negedge clk);
        chk("arb_i2", grant_i_2, 1);
        req_i_2 = 0;
        @(negedge clk); @(negedge clk); @(negedge clk);

        // Split read, 0x3C delivered after the split
        dv_pulses = 0;
        start(16'h4000, 8'h00, 0);
        addr_phase(16'h4000);
        rd_phase(8'h3C, 0);
        finish_xfer();
        chk("s_pulses", dv_pulses, 1);

        // Reset at address bit 7, then a clean write
        start(16'h800A, 8'h5C, 1);
        for (int i = 0; i < 7; i++) @(negedge clk);
        chk("pre_rst_vld", bus_data_out_valid, 1);
        rst_n = 0; #1;
        chk("mid_rst_ctl", ctl, 0);
        chk("mid_rst_sel", sel, 2'b11);
        init_req = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        do_write(16'h0ABC, 8'h81);
        chk("post_rst_t1", {target_1_valid, target_2_valid, target_3_valid, sel}, 5'b100_00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
